// File: rtl/tvg_pkg.sv
// Shared types and helpers for the tristate vector generator.
// Latency: n/a (types and a pure function only).
// Backpressure: n/a.
// Contents: FSM state enum, binary-to-gray encoder.
package tvg_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tvg_state_e;

    // Reflected binary gray code; callers truncate to their vector width.
    function automatic logic [31:0] gray_enc(input logic [31:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/tvg_tristate_drv.sv
// One tristate channel driver: pad carries val when en is high, z otherwise.
// Latency: combinational.
// Backpressure: none.
// Ports: en (drive enable), val (drive value), pad (bidirectional channel net).
module tvg_tristate_drv (
    input  logic en,
    input  logic val,
    inout  wire  pad
);

    assign pad = en ? val : 1'bz;

endmodule

// File: rtl/tristate_vector_gen.sv
// Exhaustive {0,1,z} stimulus walker over NCH tristate channels with start/stop,
// single-step, settle hold, sample strobe and sweep counter.
// Latency: new vector on the cycle after an advance; each vector held SETTLE+1 cycles.
// Backpressure: step_mode=1 holds the settled vector until step_req.
// Ports: clk, rst_n (async active-low); start/stop/step_mode/step_req control;
//   chan (inout channel nets); drv_en/drv_val observation copies; vec_idx, pass_cnt,
//   sample_stb, busy, done status.
// Build option: define TVG_GRAY_EN to drive the vector index in gray order.
module tristate_vector_gen
    import tvg_pkg::*;
#(
    parameter int NCH    = 2,
    parameter int SETTLE = 0,
    parameter int PASSES = 1,
    parameter int PW     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              step_mode,
    input  logic              step_req,
    inout  wire  [NCH-1:0]    chan,
    output logic [NCH-1:0]    drv_en,
    output logic [NCH-1:0]    drv_val,
    output logic [2*NCH-1:0]  vec_idx,
    output logic [PW-1:0]     pass_cnt,
    output logic              sample_stb,
    output logic              busy,
    output logic              done
);

    localparam int VW = 2 * NCH;
    localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
    localparam logic [HW-1:0] SETTLE_L = HW'(SETTLE);
    localparam logic [PW:0]   PASSES_L = (PW + 1)'(PASSES);

    tvg_state_e      state_q, state_d;
    logic [VW-1:0]   vec_q;
    logic [PW-1:0]   pass_q;
    logic [HW-1:0]   hold_q;
    logic            sampled_q;   // strobe already issued for the current vector

    logic            at_settle;
    logic            adv;
    logic            last_vec;
    logic            finish;
    logic            restart;
    logic [PW:0]     pass_inc;
    logic [PW-1:0]   pass_sat;
    logic [VW-1:0]   code;
    logic [NCH-1:0]  en_c;
    logic [NCH-1:0]  val_c;

    assign at_settle = (hold_q == SETTLE_L);
    assign last_vec  = (vec_q == {VW{1'b1}});
    assign pass_inc  = {1'b0, pass_q} + 1'b1;
    assign pass_sat  = (&pass_q) ? pass_q : pass_inc[PW-1:0];
    assign finish    = (PASSES != 0) && (pass_inc == PASSES_L);
    // start is only honoured outside RUN and loses to stop
    assign restart   = start && !stop && (state_q != ST_RUN);

    // Next state, advance decision and status outputs
    always_comb begin
        state_d    = state_q;
        adv        = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        sample_stb = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (restart) state_d = ST_RUN;
            end
            ST_RUN: begin
                busy       = 1'b1;
                sample_stb = at_settle && !sampled_q;
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (at_settle && (!step_mode || step_req)) begin
                    adv = 1'b1;
                    if (last_vec && finish) state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done = 1'b1;
                if (stop)         state_d = ST_IDLE;
                else if (restart) state_d = ST_RUN;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            vec_q     <= '0;
            pass_q    <= '0;
            hold_q    <= '0;
            sampled_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (restart) begin
                vec_q     <= '0;
                pass_q    <= '0;
                hold_q    <= '0;
                sampled_q <= 1'b0;
            end else if (adv) begin
                hold_q    <= '0;
                sampled_q <= 1'b0;
                if (last_vec) begin
                    // Final sweep keeps the last index visible in DONE
                    if (!finish) vec_q <= '0;
                    pass_q <= pass_sat;
                end else begin
                    vec_q <= vec_q + 1'b1;
                end
            end else if (state_q == ST_RUN && !stop) begin
                if (!at_settle) hold_q <= hold_q + 1'b1;
                if (sample_stb) sampled_q <= 1'b1;
            end
        end
    end

`ifdef TVG_GRAY_EN
    assign code = VW'(gray_enc(32'(vec_q)));
`else
    assign code = vec_q;
`endif

    // Even code bits are enables, odd bits are values
    always_comb begin
        en_c  = '0;
        val_c = '0;
        for (int i = 0; i < NCH; i++) begin
            en_c[i]  = code[2*i];
            val_c[i] = code[2*i+1];
        end
    end

    assign drv_en   = (state_q == ST_RUN) ? en_c  : '0;
    assign drv_val  = (state_q == ST_RUN) ? val_c : '0;
    assign vec_idx  = vec_q;
    assign pass_cnt = pass_q;

    for (genvar g = 0; g < NCH; g++) begin : g_drv
        tvg_tristate_drv u_drv (
            .en  (drv_en[g]),
            .val (drv_val[g]),
            .pad (chan[g])
        );
    end

endmodule

// File: tb/tb_tristate_vector_gen.sv
// Bench for tristate_vector_gen: three instances (default, SETTLE=2 step mode, PASSES=3).
// Channel nets carry pullups, so an undriven (z) channel reads back as 1.
module tb_tristate_vector_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic start_a, stop_a, step_mode_a, step_req_a;
    logic start_s, stop_s, step_mode_s, step_req_s;
    logic start_p, stop_p, step_mode_p, step_req_p;

    wire  [1:0] chan_a, chan_s, chan_p;
    pullup (chan_a[0]);
    pullup (chan_a[1]);
    pullup (chan_s[0]);
    pullup (chan_s[1]);
    pullup (chan_p[0]);
    pullup (chan_p[1]);

    logic [1:0]  en_a, val_a, en_s, val_s, en_p, val_p;
    logic [3:0]  vec_a, vec_s, vec_p;
    logic [15:0] pc_a, pc_s, pc_p;
    logic        stb_a, busy_a, done_a;
    logic        stb_s, busy_s, done_s;
    logic        stb_p, busy_p, done_p;

    tristate_vector_gen dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .stop(stop_a),
        .step_mode(step_mode_a), .step_req(step_req_a), .chan(chan_a),
        .drv_en(en_a), .drv_val(val_a), .vec_idx(vec_a), .pass_cnt(pc_a),
        .sample_stb(stb_a), .busy(busy_a), .done(done_a)
    );

    tristate_vector_gen #(.SETTLE(2)) dut_s (
        .clk(clk), .rst_n(rst_n), .start(start_s), .stop(stop_s),
        .step_mode(step_mode_s), .step_req(step_req_s), .chan(chan_s),
        .drv_en(en_s), .drv_val(val_s), .vec_idx(vec_s), .pass_cnt(pc_s),
        .sample_stb(stb_s), .busy(busy_s), .done(done_s)
    );

    tristate_vector_gen #(.PASSES(3)) dut_p (
        .clk(clk), .rst_n(rst_n), .start(start_p), .stop(stop_p),
        .step_mode(step_mode_p), .step_req(step_req_p), .chan(chan_p),
        .drv_en(en_p), .drv_val(val_p), .vec_idx(vec_p), .pass_cnt(pc_p),
        .sample_stb(stb_p), .busy(busy_p), .done(done_p)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] code_of(input logic [3:0] v);
`ifdef TVG_GRAY_EN
        return v ^ (v >> 1);
`else
        return v;
`endif
    endfunction

    function automatic logic [1:0] en_of(input logic [3:0] c);
        return {c[2], c[0]};
    endfunction

    function automatic logic [1:0] val_of(input logic [3:0] c);
        return {c[3], c[1]};
    endfunction

    // Pulled-up net value: driven bits follow val, undriven bits read 1
    function automatic logic [1:0] pulled(input logic [1:0] en, input logic [1:0] val);
        return (val & en) | ~en;
    endfunction

    typedef struct {
        logic [3:0] vec;
        logic [1:0] en;
        logic [1:0] val;
    } vec_rec_t;

    typedef struct {
        logic [3:0]  vec;
        logic [15:0] pc;
    } sb_t;

    vec_rec_t   tbl[5];
    sb_t        sbq[$];
    logic [1:0] obs_en[16];
    logic [1:0] obs_val[16];

    initial begin
        sb_t        e;
        int         cycles;
        logic [3:0] prev_bits;

        // Hand-derived channel maps for selected vectors
`ifdef TVG_GRAY_EN
        tbl[0] = '{vec: 4'd0,  en: 2'b00, val: 2'b00};
        tbl[1] = '{vec: 4'd5,  en: 2'b11, val: 2'b01};
        tbl[2] = '{vec: 4'd6,  en: 2'b11, val: 2'b00};
        tbl[3] = '{vec: 4'd10, en: 2'b11, val: 2'b11};
        tbl[4] = '{vec: 4'd15, en: 2'b00, val: 2'b10};
`else
        tbl[0] = '{vec: 4'd0,  en: 2'b00, val: 2'b00};
        tbl[1] = '{vec: 4'd5,  en: 2'b11, val: 2'b00};
        tbl[2] = '{vec: 4'd6,  en: 2'b10, val: 2'b01};
        tbl[3] = '{vec: 4'd10, en: 2'b00, val: 2'b11};
        tbl[4] = '{vec: 4'd15, en: 2'b11, val: 2'b11};
`endif
        for (int i = 0; i < 16; i++) begin
            obs_en[i]  = 2'b00;
            obs_val[i] = 2'b00;
        end

        rst_n = 1'b0;
        start_a = 0; stop_a = 0; step_mode_a = 0; step_req_a = 0;
        start_s = 0; stop_s = 0; step_mode_s = 1; step_req_s = 0;
        start_p = 0; stop_p = 0; step_mode_p = 0; step_req_p = 0;

        // ---- reset state
        #2;
        check("rst_chan",  32'(chan_a), 32'(2'b11));
        check("rst_busy",  32'(busy_a), 0);
        check("rst_done",  32'(done_a), 0);
        check("rst_stb",   32'(stb_a),  0);
        check("rst_vec",   32'(vec_a),  0);
        check("rst_pc",    32'(pc_a),   0);
        check("rst_en",    32'(en_a),   0);
        rst_n = 1'b1;

        // ---- free sweep with scoreboard
        for (int v = 0; v < 16; v++) begin
            e.vec = 4'(v);
            e.pc  = 16'd0;
            sbq.push_back(e);
        end
        start_a = 1;
        cyc();
        start_a = 0;
        cycles = 0;
        prev_bits = 4'd0;
        for (int c = 0; c < 40 && sbq.size() > 0; c++) begin
            if (stb_a) begin
                e = sbq.pop_front();
                check("sweep_vec",  32'(vec_a),  32'(e.vec));
                check("sweep_pc",   32'(pc_a),   32'(e.pc));
                check("sweep_en",   32'(en_a),   32'(en_of(code_of(e.vec))));
                check("sweep_val",  32'(val_a),  32'(val_of(code_of(e.vec))));
                check("sweep_chan", 32'(chan_a), 32'(pulled(en_of(code_of(e.vec)), val_of(code_of(e.vec)))));
                check("sweep_busy", 32'(busy_a), 1);
                obs_en[vec_a]  = en_a;
                obs_val[vec_a] = val_a;
`ifdef TVG_GRAY_EN
                if (e.vec != 4'd0)
                    check("gray_one_bit", 32'($countones({val_a, en_a} ^ prev_bits)), 1);
`endif
                prev_bits = {val_a, en_a};
            end
            cycles++;
            cyc();
        end
        check("sweep_sb_drained", 32'(sbq.size()), 0);
        check("sweep_cycles",     32'(cycles), 16);
        check("sweep_done",       32'(done_a), 1);
        check("sweep_busy_end",   32'(busy_a), 0);
        check("sweep_chan_end",   32'(chan_a), 32'(2'b11));
        check("sweep_en_end",     32'(en_a),   0);
        check("sweep_pc_end",     32'(pc_a),   1);
        check("sweep_vec_end",    32'(vec_a),  15);
        check("sweep_stb_end",    32'(stb_a),  0);

        for (int i = 0; i < 5; i++) begin
            check($sformatf("tbl_en_v%0d", tbl[i].vec),  32'(obs_en[tbl[i].vec]),  32'(tbl[i].en));
            check($sformatf("tbl_val_v%0d", tbl[i].vec), 32'(obs_val[tbl[i].vec]), 32'(tbl[i].val));
        end

        // ---- restart from DONE, start ignored in RUN, stop at vec 7
        start_a = 1;
        cyc();
        start_a = 0;
        check("restart_vec",  32'(vec_a),  0);
        check("restart_busy", 32'(busy_a), 1);
        check("restart_pc",   32'(pc_a),   0);
        for (int c = 0; c < 20 && vec_a != 4'd3; c++) cyc();
        check("reach_vec3", 32'(vec_a), 3);
        start_a = 1;
        cyc();
        start_a = 0;
        check("start_in_run_ignored", 32'(vec_a), 4);
        for (int c = 0; c < 20 && vec_a != 4'd7; c++) cyc();
        check("reach_vec7", 32'(vec_a), 7);
        stop_a = 1;
        cyc();
        stop_a = 0;
        check("stop_busy", 32'(busy_a), 0);
        check("stop_done", 32'(done_a), 0);
        check("stop_vec",  32'(vec_a),  7);
        check("stop_chan", 32'(chan_a), 32'(2'b11));
        check("stop_en",   32'(en_a),   0);
        cyc();
        check("idle_vec_hold", 32'(vec_a), 7);
        start_a = 1;
        cyc();
        start_a = 0;
        check("stop_restart_vec",  32'(vec_a),  0);
        check("stop_restart_busy", 32'(busy_a), 1);
        stop_a = 1;
        cyc();
        stop_a = 0;

        // ---- settle + step mode (SETTLE=2)
        start_s = 1;
        cyc();
        start_s = 0;
        check("step_h0_stb", 32'(stb_s), 0);
        check("step_h0_vec", 32'(vec_s), 0);
        step_req_s = 1;                 // early request, must be dropped
        cyc();
        step_req_s = 0;
        check("step_h1_vec", 32'(vec_s), 0);
        check("step_h1_stb", 32'(stb_s), 0);
        cyc();
        check("step_h2_stb", 32'(stb_s), 1);
        check("step_h2_vec", 32'(vec_s), 0);
        cyc();
        check("step_wait_stb", 32'(stb_s), 0);
        check("step_wait_vec", 32'(vec_s), 0);
        cyc();
        check("step_wait2_stb", 32'(stb_s), 0);
        step_req_s = 1;
        cyc();
        step_req_s = 0;
        check("step_adv_vec", 32'(vec_s), 1);
        check("step_adv_stb", 32'(stb_s), 0);
        cyc();
        check("step_v1_h1_stb", 32'(stb_s), 0);
        cyc();
        check("step_v1_h2_stb", 32'(stb_s), 1);
        check("step_v1_vec",    32'(vec_s), 1);
        check("step_v1_en",     32'(en_s),  32'(en_of(code_of(4'd1))));
        stop_s = 1;
        cyc();
        stop_s = 0;
        check("step_stop_busy", 32'(busy_s), 0);

        // ---- multi-pass (PASSES=3)
        for (int p = 0; p < 3; p++) begin
            for (int v = 0; v < 16; v++) begin
                e.vec = 4'(v);
                e.pc  = 16'(p);
                sbq.push_back(e);
            end
        end
        start_p = 1;
        cyc();
        start_p = 0;
        cycles = 0;
        for (int c = 0; c < 100 && sbq.size() > 0; c++) begin
            if (stb_p) begin
                e = sbq.pop_front();
                check("mp_vec",  32'(vec_p),  32'(e.vec));
                check("mp_pc",   32'(pc_p),   32'(e.pc));
                check("mp_done", 32'(done_p), 0);
            end
            cycles++;
            cyc();
        end
        check("mp_sb_drained", 32'(sbq.size()), 0);
        check("mp_cycles",     32'(cycles), 48);
        check("mp_done_end",   32'(done_p), 1);
        check("mp_pc_end",     32'(pc_p),   3);
        check("mp_vec_end",    32'(vec_p),  15);
        check("mp_chan_end",   32'(chan_p), 32'(2'b11));

        // ---- asynchronous reset mid-sweep
        start_a = 1;
        cyc();
        start_a = 0;
        cyc();
        cyc();
        check("pre_rst_vec", 32'(vec_a), 2);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_a), 0);
        check("arst_vec",  32'(vec_a),  0);
        check("arst_chan", 32'(chan_a), 32'(2'b11));
        check("arst_en",   32'(en_a),   0);
        check("arst_pc",   32'(pc_p),   0);
        check("arst_done", 32'(done_p), 0);
        check("arst_stb",  32'(stb_a),  0);
        #2;
        rst_n = 1'b1;
        cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
